// File: rtl/dmem_sized.sv
// Byte/half/word data memory with registered one-cycle loads, sign/zero extension and error reporting.
// Optional clear-on-reset sweep is enabled by defining DMEM_CLEAR_EN.
module dmem_sized #(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              wsignal,
    input  logic              rsignal,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              err,
    output logic              busy
);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_W = (IDX_W + 1)'(DEPTH);

    logic [31:0] mem [DEPTH];

    logic [IDX_W-1:0]  word_idx;
    logic [MEM_AW-1:0] mem_idx;
    logic [1:0]        lane;
    logic              in_range;
    logic              bad;
    logic              accept;
    logic              load_go;
    logic              store_go;
    logic [3:0]        lane_we;
    logic [31:0]       wdata_lane;

    logic [31:0]       rdata_p1;
    logic              vld_p1;
    logic              err_p1;

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] ofs,
                                                input logic [1:0] sz, input logic sx);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        res;
        b = word[ofs*8 +: 8];
        h = ofs[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   res = sx ? 32'($signed(b)) : {24'd0, b};
            2'b01:   res = sx ? 32'($signed(h)) : {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    assign word_idx = addr[ADDR_W-1:2];
    assign mem_idx  = word_idx[MEM_AW-1:0];
    assign lane     = addr[1:0];
    assign in_range = {1'b0, word_idx} < DEPTH_W;

    always_comb begin
        bad = 1'b0;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr[0];
            2'b10:   bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        if (!in_range)
            bad = 1'b1;
    end

    assign accept   = ena && (wsignal || rsignal) && !busy && !rst;
    assign store_go = accept && wsignal && !bad;
    assign load_go  = accept && rsignal && !wsignal;

    always_comb begin
        lane_we    = 4'b0000;
        wdata_lane = wdata;
        case (size)
            2'b00: begin
                wdata_lane = {4{wdata[7:0]}};
                if (store_go) lane_we = 4'b0001 << lane;
            end
            2'b01: begin
                wdata_lane = {2{wdata[15:0]}};
                if (store_go) lane_we = lane[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                if (store_go) lane_we = 4'b1111;
            end
            default: lane_we = 4'b0000;
        endcase
    end

`ifdef DMEM_CLEAR_EN
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] IDLE  = 1'b1;
    localparam logic [MEM_AW-1:0] LAST_WORD = MEM_AW'(DEPTH - 1);

    logic [0:0]        state;
    logic [MEM_AW-1:0] clr_cnt;
    logic              clr_we;

    assign busy   = rst || (state == CLEAR);
    assign clr_we = (state == CLEAR) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == LAST_WORD)
                state <= IDLE;
        end
    end

    // Sweep writes and lane stores share one write port; they never overlap since busy blocks stores.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else begin
            for (int l = 0; l < 4; l++)
                if (lane_we[l])
                    mem[mem_idx][l*8 +: 8] <= wdata_lane[l*8 +: 8];
        end
    end
`else
    assign busy = rst;

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++)
            if (lane_we[l])
                mem[mem_idx][l*8 +: 8] <= wdata_lane[l*8 +: 8];
    end
`endif

    // Response stage: load result, valid and error registered for the cycle after the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= load_go;
            err_p1 <= accept && bad;
            if (load_go)
                rdata_p1 <= bad ? 32'd0 : load_extend(mem[mem_idx], lane, size, sext);
        end
    end

    assign rdata  = rdata_p1;
    assign rvalid = vld_p1;
    assign err    = err_p1;

endmodule

// File: tb/tb_dmem_sized.sv
// Scoreboard bench for dmem_sized: directed stores/loads push expected responses, a monitor pops them.
module tb_dmem_sized;
    logic        clk;
    logic        rst;
    logic        ena;
    logic        wsignal;
    logic        rsignal;
    logic [12:0] addr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
    logic        busy;

    typedef struct {
        logic        v;
        logic        e;
        logic [31:0] d;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   nbusy;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    dmem_sized #(.DEPTH(2048), .ADDR_W(13)) dut (
        .clk(clk), .rst(rst), .ena(ena), .wsignal(wsignal), .rsignal(rsignal),
        .addr(addr), .size(size), .sext(sext), .wdata(wdata),
        .rdata(rdata), .rvalid(rvalid), .err(err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid || err) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got rvalid=%b err=%b rdata=%h expected none", rvalid, err, rdata);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("rvalid", 32'(rvalid), 32'(e.v));
                check("err", 32'(err), 32'(e.e));
                if (e.v)
                    check("rdata", rdata, e.d);
            end
        end
    end

    task automatic idle();
        @(posedge clk); #1;
        ena = 1'b0; wsignal = 1'b0; rsignal = 1'b0;
    endtask

    task automatic store(input logic [12:0] a, input logic [1:0] sz, input logic [31:0] d,
                         input logic exp_err, input logic also_read = 1'b0);
        exp_t e;
        @(posedge clk); #1;
        ena = 1'b1; wsignal = 1'b1; rsignal = also_read;
        addr = a; size = sz; sext = 1'b0; wdata = d;
        if (exp_err) begin
            e.v = 1'b0; e.e = 1'b1; e.d = 32'd0;
            sbq.push_back(e);
        end
    endtask

    task automatic load(input logic [12:0] a, input logic [1:0] sz, input logic sx,
                        input logic [31:0] exp_d, input logic exp_err);
        exp_t e;
        @(posedge clk); #1;
        ena = 1'b1; wsignal = 1'b0; rsignal = 1'b1;
        addr = a; size = sz; sext = sx; wdata = 32'd0;
        e.v = 1'b1; e.e = exp_err; e.d = exp_d;
        sbq.push_back(e);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    task automatic drain();
        idle();
        repeat (3) @(posedge clk);
        check("sb_drain", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ena = 1'b0; wsignal = 1'b0; rsignal = 1'b0;
        addr = '0; size = SZ_W; sext = 1'b0; wdata = '0;
        @(posedge clk);
        @(negedge clk);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        count_busy(nbusy);
`ifdef DMEM_CLEAR_EN
        check("busy_cycles", 32'(nbusy), 32'd2048);
`else
        check("busy_cycles", 32'(nbusy), 32'd0);
        store(13'h7FC, SZ_W, 32'd0, 1'b0);
`endif
        load(13'h7FC, SZ_W, 1'b0, 32'd0, 1'b0);

        store(13'h010, SZ_W, 32'h11223344, 1'b0);
        load(13'h013, SZ_B, 1'b0, 32'h00000011, 1'b0);
        load(13'h012, SZ_H, 1'b0, 32'h00001122, 1'b0);
        load(13'h010, SZ_B, 1'b1, 32'h00000044, 1'b0);
        load(13'h010, SZ_H, 1'b1, 32'h00003344, 1'b0);
        load(13'h012, SZ_B, 1'b1, 32'h00000022, 1'b0);

        store(13'h020, SZ_W, 32'd0, 1'b0);
        store(13'h021, SZ_B, 32'h00000080, 1'b0);
        load(13'h020, SZ_W, 1'b0, 32'h00008000, 1'b0);
        load(13'h021, SZ_B, 1'b1, 32'hFFFFFF80, 1'b0);
        load(13'h021, SZ_B, 1'b0, 32'h00000080, 1'b0);
        store(13'h022, SZ_H, 32'h0000A5C3, 1'b0);
        load(13'h020, SZ_W, 1'b1, 32'hA5C38000, 1'b0);
        load(13'h022, SZ_H, 1'b1, 32'hFFFFA5C3, 1'b0);
        load(13'h022, SZ_H, 1'b0, 32'h0000A5C3, 1'b0);
        drain();

        store(13'h004, SZ_W, 32'hCAFEF00D, 1'b0);
        load(13'h006, SZ_W, 1'b0, 32'd0, 1'b1);
        load(13'h005, SZ_H, 1'b0, 32'd0, 1'b1);
        load(13'h004, SZ_X, 1'b0, 32'd0, 1'b1);
        store(13'h006, SZ_W, 32'h12345678, 1'b1);
        load(13'h004, SZ_W, 1'b0, 32'hCAFEF00D, 1'b0);

        store(13'h030, SZ_W, 32'h0BADF00D, 1'b0, 1'b1);
        load(13'h030, SZ_W, 1'b0, 32'h0BADF00D, 1'b0);
        @(posedge clk); #1;
        ena = 1'b0; wsignal = 1'b0; rsignal = 1'b1; addr = 13'h030; size = SZ_W;
        drain();

        store(13'h040, SZ_W, 32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 4; i++)
            load(13'h040, SZ_W, 1'b0, 32'hDEADBEEF, 1'b0);
        load(13'h013, SZ_B, 1'b0, 32'h00000011, 1'b0);
        drain();
        repeat (2) @(negedge clk);
        check("rdata_hold", rdata, 32'h00000011);

`ifdef DMEM_CLEAR_EN
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        ena = 1'b1; rsignal = 1'b1; wsignal = 1'b0; addr = 13'h040; size = SZ_W;
        @(posedge clk); #1;
        ena = 1'b0; rsignal = 1'b0;
        repeat (48) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        count_busy(nbusy);
        check("busy_restart", 32'(nbusy), 32'd2048);
        load(13'h040, SZ_W, 1'b0, 32'd0, 1'b0);
        drain();
`else
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("busy_after_rst", 32'(busy), 32'd0);
        check("rdata_after_rst", rdata, 32'd0);
        load(13'h040, SZ_W, 1'b0, 32'hDEADBEEF, 1'b0);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_sized.md
# dmem_sized

Parametrised data memory for the 31-instruction MIPS core, successor to the fixed 32-word data memory. Adds byte/halfword/word access with per-lane write enables, sign/zero extension on loads, a registered one-cycle read with `rvalid`, alignment and range error reporting, and an optional clear-on-reset sweep. Sits between the execute stage's load/store path and on-chip RAM.

## Interface
- `DEPTH`, 2048: number of 32-bit words; power of two, ≥ 2.
- `ADDR_W`, 13: byte-address width; must satisfy 2^ADDR_W ≥ 4·DEPTH.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `ena`  in  1  chip enable; requests are ignored when low.
- `wsignal`  in  1  store request.
- `rsignal`  in  1  load request.
- `addr`  in  ADDR_W  byte address; word index = `addr[ADDR_W-1:2]`, lane = `addr[1:0]`.
- `size`  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as error).
- `sext`  in  1  loads only: 1 sign-extend, 0 zero-extend.
- `wdata`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `rdata`  out  32  load result, extended to 32 bits.
- `rvalid`  out  1  one-cycle pulse: `rdata` holds a new load result.
- `err`  out  1  one-cycle pulse: the previous cycle's request was rejected.
- `busy`  out  1  requests are not accepted while high.

## Operation
- Request accepted when `ena && (wsignal || rsignal) && !busy && !rst`.
- If `wsignal` and `rsignal` are both high, the store executes and the load is dropped; no `rvalid`.
- Error conditions, evaluated in the request cycle:
  - half with `addr[0]=1`;
  - word with `addr[1:0]≠0`;
  - `size=11`;
  - word index ≥ `DEPTH`.
- Erroring requests:
  - store: no lanes written;
  - load: `rdata` ← 0 with `rvalid=1`;
  - both cases: `err=1`.
- Store lane enables, little-endian:
  - byte: lane `addr[1:0]` ← `wdata[7:0]`;
  - half: lanes {`addr[1]`·2, +1} ← `wdata[15:0]`;
  - word: all four lanes.
  - Lanes not written keep their contents.
- Load extraction: select the byte/half at the lane offset, then extend per `sext`. Word loads ignore `sext`.
- Output state machine, states CLEAR, IDLE:
  - CLEAR: a counter sweeps word 0..DEPTH-1, writing 0 one word per cycle; `busy=1`; goes to IDLE after word DEPTH-1 is written.
  - IDLE: `busy=0`; one request per cycle.
- `rdata` holds its last value between loads. It changes only on a load response or reset.

## Timing
- Reset values: `rdata=0`, `rvalid=0`, `err=0`, `busy=1`. The state machine enters CLEAR with the counter at 0.
- Store accepted in cycle T: memory is updated at the edge ending T. A load of the same address issued in T+1 returns the new data.
- Load accepted in cycle T: `rdata`/`rvalid` are valid during T+1. Latency is 1 cycle, throughput 1 per cycle; back-to-back loads give consecutive `rvalid` pulses.
- `err` is asserted in T+1 for a request accepted in T, aligned with `rvalid` for loads.
- Load in T+1 at the same word as a store in T: returns post-store data. The store in T+1 itself is not forwarded.
- `rst` asserted mid-CLEAR restarts the sweep at word 0. `rst` asserted mid-request drops the response: `rvalid` and `err` are 0 in the next cycle.
- Requests presented while `busy=1` are ignored. No `rvalid` or `err` is produced; the requester must hold or retry.

## Configuration
- `DMEM_CLEAR_EN`
  - Defined: CLEAR sweep as above; `busy` is high for DEPTH cycles after `rst` deasserts.
  - Undefined: no CLEAR state, no counter. `busy` is high only during reset cycles, and requests are accepted in the first cycle after `rst` falls. Memory contents persist across reset and are undefined at power-up.

## Test plan
- Reset, then wait (with `DMEM_CLEAR_EN`, DEPTH=2048): `busy` is high for exactly 2048 cycles after `rst` falls. A word load of 0x7FC then returns `rdata=0`, `rvalid=1`.
- Word store 0x11223344 @0x10, then byte load @0x13 with `sext=0`: `rdata=0x00000011`. Half load @0x12: `rdata=0x00001122`.
- Byte store 0x80 @0x21 over a word 0: word load @0x20 returns 0x00008000. Byte load @0x21 with `sext=1` returns 0xFFFFFF80.
- Word load @0x06 and half load @0x05: each gives `err=1`, `rvalid=1`, `rdata=0`. A word store @0x06 leaves memory unchanged; a subsequent load @0x04 returns the prior value.
- Word store 0xDEADBEEF @0x40 in T, word load @0x40 in T+1: `rdata=0xDEADBEEF` in T+2. Loads in T+1..T+4 produce 4 consecutive `rvalid` pulses.
- `rst` pulsed for 1 cycle at cycle 100 of the sweep: the sweep restarts and `busy` stays high 2048 more cycles. A load issued during `busy` produces no `rvalid`.
